// File: rtl/adc_responder_pkg.sv
// adc_responder_pkg
//   Shared constants for the ADC stand-in: FSM state encoding, channel count,
//   channel slice width and address width.
package adc_responder_pkg;

  localparam int NUM_CH = 8;   // channels on the flat channel_data bus
  localparam int CH_W   = 8;   // bits per channel code
  localparam int ADDR_W = 3;   // channel address width

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CONVERT = 2'd2;

endpackage

// File: rtl/adc_responder_sync.sv
// sync_ff
//   STAGES-deep single-bit synchronizer with asynchronous active-high reset.
//   Ports:
//     clk  - destination clock
//     rst  - asynchronous active-high reset, clears every stage
//     d    - asynchronous input bit
//     q    - synchronized output (last stage)
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[STAGES-2:0], d};
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/adc_responder.sv
// adc_responder
//   Synthesizable stand-in for an eight-channel SAR ADC. A synchronized start
//   rise arms the converter and latches the channel address; the start fall
//   samples the selected channel and begins a fixed CONV_CYCLES conversion,
//   after which the code is presented with eoc high.
//   Ports:
//     CLK100MHZ    - system clock (only clock)
//     reset        - asynchronous active-high reset
//     start        - conversion start, asynchronous to CLK100MHZ
//     address      - channel select, stable while start is high
//     channel_data - channel n in bits [8n+7:8n]
//     oe           - output enable for analog_input
//     analog_input - last completed code when oe=1, else 0
//     eoc          - end of conversion, low while converting
//     busy         - high in ARMED or CONVERT
//     conv_count   - completed conversions, wraps modulo 2^16
module adc_responder
  import adc_responder_pkg::*;
#(
  parameter int CONV_CYCLES = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   CLK100MHZ,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      address,
  input  logic [NUM_CH*CH_W-1:0] channel_data,
  input  logic                   oe,
  output logic [CH_W-1:0]        analog_input,
  output logic                   eoc,
  output logic                   busy,
  output logic [15:0]            conv_count
);

  localparam logic [15:0] LAST_CNT = 16'(CONV_CYCLES - 1);

  logic              w_start_s;
  logic [ADDR_W-1:0] w_addr_s;
  logic              w_rise;
  logic              w_fall;
  logic [CH_W-1:0]   w_sel;

  logic [1:0]        r_state;
  logic              r_start_d;
  logic [ADDR_W-1:0] r_addr_q;
  logic [CH_W-1:0]   r_hold_q;
  logic [CH_W-1:0]   r_data_q;
  logic [15:0]       r_cnt;
  logic              r_eoc;
  logic              r_busy;
  logic [15:0]       r_conv_count;

  sync_ff #(.STAGES(SYNC_STAGES)) u_start_sync (
    .clk (CLK100MHZ),
    .rst (reset),
    .d   (start),
    .q   (w_start_s)
  );

  // Address bits get the same latency as start, so they line up with the
  // synchronized rise that latches them.
  for (genvar b = 0; b < ADDR_W; b++) begin : g_addr_sync
    sync_ff #(.STAGES(SYNC_STAGES)) u_addr_sync (
      .clk (CLK100MHZ),
      .rst (reset),
      .d   (address[b]),
      .q   (w_addr_s[b])
    );
  end

  assign w_rise = w_start_s & ~r_start_d;
  assign w_fall = ~w_start_s & r_start_d;
  assign w_sel  = channel_data[r_addr_q*CH_W +: CH_W];

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_start_d    <= 1'b0;
      r_addr_q     <= '0;
      r_hold_q     <= '0;
      r_data_q     <= '0;
      r_cnt        <= '0;
      r_eoc        <= 1'b1;
      r_busy       <= 1'b0;
      r_conv_count <= '0;
    end else begin
      r_start_d <= w_start_s;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_addr_q <= w_addr_s;
            r_eoc    <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          // No timeout: a start held high keeps us armed indefinitely.
          if (w_fall) begin
            r_hold_q <= w_sel;
            r_cnt    <= '0;
            r_state  <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          // A new start rise outranks completion, even on the terminal count.
          if (w_rise) begin
            r_addr_q <= w_addr_s;
            r_state  <= ST_ARMED;
          end else if (r_cnt == LAST_CNT) begin
            r_data_q     <= r_hold_q;
            r_eoc        <= 1'b1;
            r_busy       <= 1'b0;
            r_conv_count <= r_conv_count + 16'd1;
            r_state      <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_eoc   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign analog_input = oe ? r_data_q : '0;
  assign eoc          = r_eoc;
  assign busy         = r_busy;
  assign conv_count   = r_conv_count;

endmodule

// File: tb/tb_adc_responder.sv
module tb_adc_responder;

  logic        CLK100MHZ = 1'b0;
  logic        reset;
  logic        start, start_w;
  logic [2:0]  address;
  logic [63:0] channel_data;
  logic        oe;
  logic [7:0]  analog_input, analog_w;
  logic        eoc, eoc_w, busy, busy_w;
  logic [15:0] conv_count, count_w;

  int vectors = 0;
  int miscompares = 0;
  int exp_count = 0;

  always #5 CLK100MHZ = ~CLK100MHZ;

  adc_responder #(.CONV_CYCLES(64), .SYNC_STAGES(2)) dut (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .start(start), .address(address),
    .channel_data(channel_data), .oe(oe), .analog_input(analog_input),
    .eoc(eoc), .busy(busy), .conv_count(conv_count)
  );

  // Shortest legal conversion and deepest synchronizer.
  adc_responder #(.CONV_CYCLES(2), .SYNC_STAGES(3)) dut_w (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .start(start_w), .address(address),
    .channel_data(channel_data), .oe(oe), .analog_input(analog_w),
    .eoc(eoc_w), .busy(busy_w), .conv_count(count_w)
  );

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK100MHZ); #1; end
  endtask

  // Bounded wait for eoc high; ok=0 on timeout.
  task automatic wait_eoc(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (eoc) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_conv(input logic [2:0] a, output bit ok);
    address = a;
    tick(1);
    start = 1'b1;
    tick(4);
    start = 1'b0;
    wait_eoc(ok);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; start_w = 1'b0; address = '0; oe = 1'b1;
    for (int n = 0; n < 8; n++) channel_data[8*n +: 8] = 8'h10 + 8'(n);
    tick(3);
    vectors++;
    if (eoc !== 1'b1 || busy !== 1'b0 || analog_input !== 8'h00 || conv_count !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_state: eoc=%b busy=%b ai=%h cnt=%h, want 1 0 00 0000", eoc, busy, analog_input, conv_count);
    end
    reset = 1'b0;
    tick(2);
    vectors++;
    if (eoc !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: eoc=%b busy=%b, want 1 0", eoc, busy);
    end
  endtask

  task automatic test_single;
    bit ok;
    address = 3'd3;
    tick(1);
    start = 1'b1;
    tick(2);
    vectors++;
    if (eoc !== 1'b1) begin
      miscompares++; $display("FAIL eoc_fall_early: eoc=%b at cycle 2, want 1", eoc);
    end
    tick(1);
    vectors++;
    if (eoc !== 1'b0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL eoc_fall: eoc=%b busy=%b at cycle 3, want 0 1", eoc, busy);
    end
    tick(7);
    start = 1'b0;
    tick(66);
    vectors++;
    if (eoc !== 1'b0) begin
      miscompares++; $display("FAIL eoc_rise_early: eoc=%b one cycle before completion, want 0", eoc);
    end
    tick(1);
    exp_count++;
    vectors++;
    if (eoc !== 1'b1 || busy !== 1'b0 || analog_input !== 8'h13 || conv_count !== 16'(exp_count)) begin
      miscompares++;
      $display("FAIL single_done: eoc=%b busy=%b ai=%h cnt=%0d, want 1 0 13 %0d", eoc, busy, analog_input, conv_count, exp_count);
    end
    ok = 1'b1;
  endtask

  task automatic test_sweep;
    bit ok;
    reset = 1'b1; tick(1); reset = 1'b0; tick(1);
    exp_count = 0;
    for (int a = 0; a < 8; a++) begin
      do_conv(3'(a), ok);
      exp_count++;
      vectors++;
      if (!ok || analog_input !== 8'h10 + 8'(a)) begin
        miscompares++;
        $display("FAIL sweep_ch%0d: done=%b ai=%h, want 1 %h", a, ok, analog_input, 8'h10 + 8'(a));
      end
    end
    vectors++;
    if (conv_count !== 16'd8) begin
      miscompares++; $display("FAIL sweep_count: cnt=%0d, want 8", conv_count);
    end
  endtask

  task automatic test_abort;
    bit ok;
    bit eoc_seen = 1'b0;
    address = 3'd2;
    tick(1);
    start = 1'b1;
    tick(4);
    start = 1'b0;
    for (int i = 0; i < 23; i++) begin tick(1); if (eoc) eoc_seen = 1'b1; end
    address = 3'd5;
    tick(1); if (eoc) eoc_seen = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(1); if (eoc) eoc_seen = 1'b1; end
    start = 1'b0;
    vectors++;
    if (eoc_seen) begin
      miscompares++; $display("FAIL abort_eoc: eoc went high between starts, want low");
    end
    wait_eoc(ok);
    exp_count++;
    vectors++;
    if (!ok || analog_input !== 8'h15 || conv_count !== 16'(exp_count)) begin
      miscompares++;
      $display("FAIL abort_done: done=%b ai=%h cnt=%0d, want 1 15 %0d", ok, analog_input, conv_count, exp_count);
    end
  endtask

  // Start rise lands on the terminal-count edge: abort must win.
  task automatic test_abort_wins;
    bit ok;
    address = 3'd1;
    tick(1);
    start = 1'b1;
    tick(4);
    start = 1'b0;
    tick(3 + 61);
    address = 3'd7;
    start = 1'b1;
    tick(3);
    vectors++;
    if (eoc !== 1'b0 || busy !== 1'b1 || conv_count !== 16'(exp_count) || analog_input !== 8'h15) begin
      miscompares++;
      $display("FAIL abort_wins: eoc=%b busy=%b cnt=%0d ai=%h, want 0 1 %0d 15", eoc, busy, conv_count, exp_count, analog_input);
    end
    tick(2);
    start = 1'b0;
    wait_eoc(ok);
    exp_count++;
    vectors++;
    if (!ok || analog_input !== 8'h17 || conv_count !== 16'(exp_count)) begin
      miscompares++;
      $display("FAIL abort_wins_done: done=%b ai=%h cnt=%0d, want 1 17 %0d", ok, analog_input, conv_count, exp_count);
    end
  endtask

  task automatic test_freeze_oe;
    bit ok;
    channel_data[39:32] = 8'hAA;
    address = 3'd4;
    tick(1);
    start = 1'b1;
    tick(4);
    start = 1'b0;
    tick(13);
    channel_data[39:32] = 8'h55;
    wait_eoc(ok);
    exp_count++;
    vectors++;
    if (!ok || analog_input !== 8'hAA) begin
      miscompares++; $display("FAIL freeze: done=%b ai=%h, want 1 AA", ok, analog_input);
    end
    oe = 1'b0; #1;
    vectors++;
    if (analog_input !== 8'h00) begin
      miscompares++; $display("FAIL oe_low: ai=%h, want 00", analog_input);
    end
    oe = 1'b1; #1;
    vectors++;
    if (analog_input !== 8'hAA) begin
      miscompares++; $display("FAIL oe_high: ai=%h, want AA", analog_input);
    end
  endtask

  task automatic test_reset_mid;
    bit edge_seen = 1'b0;
    address = 3'd6;
    tick(1);
    start = 1'b1;
    tick(4);
    start = 1'b0;
    tick(13);
    #2 reset = 1'b1;
    #1;
    exp_count = 0;
    vectors++;
    if (eoc !== 1'b1 || busy !== 1'b0 || analog_input !== 8'h00 || conv_count !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_mid: eoc=%b busy=%b ai=%h cnt=%h, want 1 0 00 0000", eoc, busy, analog_input, conv_count);
    end
    tick(2);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin tick(1); if (eoc !== 1'b1 || busy !== 1'b0) edge_seen = 1'b1; end
    vectors++;
    if (edge_seen || conv_count !== 16'h0) begin
      miscompares++; $display("FAIL reset_mid_after: activity=%b cnt=%0d, want 0 0", edge_seen, conv_count);
    end
  endtask

  task automatic conv_w(input int cyc_to_eoc, output bit ok);
    ok = 1'b0;
    tick(1);
    start_w = 1'b1;
    tick(5);
    start_w = 1'b0;
    for (int i = 0; i < cyc_to_eoc; i++) begin
      tick(1);
      if (eoc_w) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_wrap;
    bit ok;
    address = 3'd6;
    tick(1);
    start_w = 1'b1;
    tick(5);
    start_w = 1'b0;
    tick(5);
    vectors++;
    if (eoc_w !== 1'b0) begin
      miscompares++; $display("FAIL short_conv_early: eoc=%b, want 0", eoc_w);
    end
    tick(1);
    vectors++;
    if (eoc_w !== 1'b1 || analog_w !== 8'h16 || count_w !== 16'd1) begin
      miscompares++; $display("FAIL short_conv: eoc=%b ai=%h cnt=%0d, want 1 16 1", eoc_w, analog_w, count_w);
    end
    // Stand in for 65534 earlier completions.
    force dut_w.r_conv_count = 16'hFFFE;
    #1;
    release dut_w.r_conv_count;
    conv_w(50, ok);
    vectors++;
    if (!ok || count_w !== 16'hFFFF) begin
      miscompares++; $display("FAIL wrap_pre: done=%b cnt=%h, want 1 FFFF", ok, count_w);
    end
    conv_w(50, ok);
    vectors++;
    if (!ok || count_w !== 16'h0000) begin
      miscompares++; $display("FAIL wrap: done=%b cnt=%h, want 1 0000", ok, count_w);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_sweep;
    test_abort;
    test_abort_wins;
    test_freeze_oe;
    test_reset_mid;
    test_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
